dbg_step_cmd: RTL and testbench

// Debug command decoder upstream of the CPU clock controller: takes bytes from the UART receiver,

---
 rtl/dbg_step_cmd.sv | 257 +++++++++++++++++++++++++
 tb/tb_dbg_step_cmd.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_step_cmd.sv
// Debug command decoder: turns UART bytes into stepmode/step/reset requests for the CPU clock
// controller, follows its busy handshake (including N-step bursts) and returns one status byte.
module dbg_step_cmd #(
  parameter int unsigned TIMEOUT = 1000,
  parameter int unsigned TO_W    = 16
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       ctl_stepmode,
  output logic       ctl_step,
  output logic       ctl_rst,
  input  logic       ctl_busy,
  output logic       overrun
);

  localparam logic [7:0] ChStep  = 8'h53;  // 'S'
  localparam logic [7:0] ChGo    = 8'h47;  // 'G'
  localparam logic [7:0] ChOne   = 8'h54;  // 'T'
  localparam logic [7:0] ChN     = 8'h4E;  // 'N'
  localparam logic [7:0] ChReset = 8'h58;  // 'X'
  localparam logic [7:0] ChQuery = 8'h3F;  // '?'
  localparam logic [7:0] ChEsc   = 8'h1B;
  localparam logic [7:0] RepOk   = 8'h4B;  // 'K'
  localparam logic [7:0] RepErr  = 8'h45;  // 'E'
  localparam logic [7:0] RepAbt  = 8'h41;  // 'A'

  localparam logic [TO_W-1:0] ToLimit = TO_W'(TIMEOUT);

  typedef enum logic [2:0] {
    StIdle,
    StArgHi,
    StArgLo,
    StIssue,
    StWaitHi,
    StWaitLo,
    StReply
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     count_q, count_d;
  logic            cmd_rst_q, cmd_rst_d;   // current command is 'X' rather than a step
  logic            abort_q, abort_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_valid_q, tx_valid_d;
  logic            stepmode_q, stepmode_d;
  logic            step_q, step_d;
  logic            rst_req_q, rst_req_d;
  logic            overrun_q, overrun_d;

  logic            do_reply;
  logic [7:0]      reply_byte;
  logic [TO_W-1:0] to_inc;

  assign to_inc = to_cnt_q + TO_W'(1);

  // State and output registers; everything visible at the ports comes straight from a flop.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      count_q    <= '0;
      cmd_rst_q  <= 1'b0;
      abort_q    <= 1'b0;
      to_cnt_q   <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      stepmode_q <= 1'b0;
      step_q     <= 1'b0;
      rst_req_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      cmd_rst_q  <= cmd_rst_d;
      abort_q    <= abort_d;
      to_cnt_q   <= to_cnt_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      stepmode_q <= stepmode_d;
      step_q     <= step_d;
      rst_req_q  <= rst_req_d;
      overrun_q  <= overrun_d;
    end
  end

  // Command decode, busy handshake tracking and reply generation.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    cmd_rst_d  = cmd_rst_q;
    abort_d    = abort_q;
    to_cnt_d   = to_cnt_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    stepmode_d = stepmode_q;
    step_d     = 1'b0;
    rst_req_d  = 1'b0;
    overrun_d  = overrun_q;
    do_reply   = 1'b0;
    reply_byte = RepErr;

    // While a step is in flight only ESC is meaningful; anything else is lost.
    if (rx_valid && (state_q == StIssue || state_q == StWaitHi || state_q == StWaitLo)) begin
      if (rx_data == ChEsc) begin
        abort_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    case (state_q)
      StIdle: begin
        abort_d = 1'b0;
        if (rx_valid) begin
          case (rx_data)
            ChStep: begin
              stepmode_d = 1'b1;
              do_reply   = 1'b1;
              reply_byte = RepOk;
            end
            ChGo: begin
              stepmode_d = 1'b0;
              do_reply   = 1'b1;
              reply_byte = RepOk;
            end
            ChOne: begin
              if (stepmode_q) begin
                count_d   = 16'd1;
                cmd_rst_d = 1'b0;
                state_d   = StIssue;
              end else begin
                do_reply = 1'b1;
              end
            end
            ChN: begin
              if (stepmode_q) begin
                state_d = StArgHi;
              end else begin
                do_reply = 1'b1;
              end
            end
            ChReset: begin
              cmd_rst_d = 1'b1;
              state_d   = StIssue;
            end
            ChQuery: begin
              do_reply   = 1'b1;
              reply_byte = {6'b001100, overrun_q, stepmode_q};
              overrun_d  = 1'b0;
            end
            default: do_reply = 1'b1;
          endcase
        end
      end

      StArgHi: begin
        if (rx_valid) begin
          count_d[15:8] = rx_data;
          state_d       = StArgLo;
        end
      end

      StArgLo: begin
        if (rx_valid) begin
          count_d   = {count_q[15:8], rx_data};
          cmd_rst_d = 1'b0;
          if ({count_q[15:8], rx_data} == 16'd0) begin
            do_reply   = 1'b1;
            reply_byte = RepOk;
          end else begin
            state_d = StIssue;
          end
        end
      end

      StIssue: begin
        // Hold the request until the controller is idle so it never sees step while busy.
        if (!ctl_busy) begin
          step_d    = !cmd_rst_q;
          rst_req_d = cmd_rst_q;
          to_cnt_d  = '0;
          state_d   = StWaitHi;
        end
      end

      StWaitHi: begin
        if (ctl_busy) begin
          to_cnt_d = '0;
          state_d  = StWaitLo;
        end else if (to_inc == ToLimit) begin
          count_d  = '0;
          do_reply = 1'b1;
        end else begin
          to_cnt_d = to_inc;
        end
      end

      StWaitLo: begin
        if (!ctl_busy) begin
          to_cnt_d = '0;
          if (cmd_rst_q) begin
            do_reply   = 1'b1;
            reply_byte = RepOk;
          end else begin
            count_d = count_q - 16'd1;
            if (count_q == 16'd1) begin
              do_reply   = 1'b1;
              reply_byte = RepOk;
            end else if (abort_q) begin
              do_reply   = 1'b1;
              reply_byte = RepAbt;
            end else begin
              state_d = StIssue;
            end
          end
        end else if (to_inc == ToLimit) begin
          count_d  = '0;
          do_reply = 1'b1;
        end else begin
          to_cnt_d = to_inc;
        end
      end

      StReply: begin
        if (rx_valid) begin
          overrun_d = 1'b1;
        end
        if (tx_valid_q && tx_ready) begin
          tx_valid_d = 1'b0;
          abort_d    = 1'b0;
          state_d    = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase

    if (do_reply) begin
      tx_data_d  = reply_byte;
      tx_valid_d = 1'b1;
      state_d    = StReply;
    end
  end

  assign tx_data      = tx_data_q;
  assign tx_valid     = tx_valid_q;
  assign ctl_stepmode = stepmode_q;
  assign ctl_step     = step_q;
  assign ctl_rst      = rst_req_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_dbg_step_cmd.sv
// Self-checking bench for dbg_step_cmd: directed scenarios plus a randomized command stream
// checked against a command-level model of replies, mode, overrun and pulse counts.
module tb_dbg_step_cmd;

  localparam int unsigned TIMEOUT = 1000;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic       ctl_stepmode;
  logic       ctl_step;
  logic       ctl_rst;
  logic       ctl_busy = 1'b0;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  // Clock-controller model knobs: 0 never busy, 1 normal, 2 busy sticks high.
  int busy_mode = 1;
  int busy_len = 3;
  int busy_left = 0;
  bit rise_pend = 1'b0;

  int step_cnt = 0;
  int rst_cnt = 0;
  int mon_bad = 0;

  dbg_step_cmd #(
    .TIMEOUT(TIMEOUT),
    .TO_W   (16)
  ) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ctl_stepmode(ctl_stepmode),
    .ctl_step    (ctl_step),
    .ctl_rst     (ctl_rst),
    .ctl_busy    (ctl_busy),
    .overrun     (overrun)
  );

  always #5 clk_in = ~clk_in;

  // Busy model: rises one cycle after a step/reset pulse and stays high busy_len cycles.
  always @(posedge clk_in) begin
    #2;
    if (rst) begin
      rise_pend = 1'b0;
      busy_left = 0;
    end else begin
      if (rise_pend) begin
        rise_pend = 1'b0;
        ctl_busy  = 1'b1;
        busy_left = busy_len;
      end else if (busy_left > 0) begin
        busy_left--;
      end
      if ((ctl_step || ctl_rst) && busy_mode != 0) rise_pend = 1'b1;
    end
    if (busy_left == 0 && !rise_pend && busy_mode != 2) ctl_busy = 1'b0;
  end

  // Pulse monitor: counts requests and records any protocol violation.
  always @(negedge clk_in) begin
    if (ctl_step) step_cnt++;
    if (ctl_rst) rst_cnt++;
    if (ctl_step && ctl_rst) mon_bad++;
    if ((ctl_step || ctl_rst) && ctl_busy) mon_bad++;
  end

  task automatic send(input logic [7:0] b);
    @(posedge clk_in);
    #2;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk_in);
    #2;
    rx_valid = 1'b0;
  endtask

  task automatic get_reply(input string name, input logic [7:0] exp, input int hold);
    int n = 0;
    bit moved = 1'b0;
    logic [7:0] d;
    @(negedge clk_in);
    while (!tx_valid && n < 5000) begin
      @(negedge clk_in);
      n++;
    end
    checks++;
    if (!tx_valid) begin
      errors++;
      $display("FAIL %s: no reply seen, expected %h", name, exp);
      return;
    end
    checks++;
    if (tx_data !== exp) begin
      errors++;
      $display("FAIL %s: reply %h, expected %h", name, tx_data, exp);
    end
    d = tx_data;
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge clk_in);
        if (!tx_valid || tx_data !== d) moved = 1'b1;
      end
      checks++;
      if (moved) begin
        errors++;
        $display("FAIL %s_hold: tx changed while stalled, now valid=%b data=%h, held %h",
                 name, tx_valid, tx_data, d);
      end
    end
    @(posedge clk_in);
    #2;
    tx_ready = 1'b1;
    @(posedge clk_in);
    #2;
    tx_ready = 1'b0;
    @(negedge clk_in);
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_ack: tx_valid %b after handshake, expected 0", name, tx_valid);
    end
  endtask

  task automatic wait_steps(input string name, input int target);
    int n = 0;
    while (step_cnt < target && n < 500) begin
      @(negedge clk_in);
      n++;
    end
    checks++;
    if (step_cnt < target) begin
      errors++;
      $display("FAIL %s: step count %0d, expected at least %0d", name, step_cnt, target);
    end
  endtask

  task automatic check_pulses(input string name, input int ds, input int dr,
                              input int exp_s, input int exp_r);
    checks++;
    if (ds != exp_s || dr != exp_r) begin
      errors++;
      $display("FAIL %s: step/rst pulses %0d/%0d, expected %0d/%0d", name, ds, dr, exp_s, exp_r);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if ({tx_valid, tx_data, ctl_stepmode, ctl_step, ctl_rst, overrun} !== 13'd0) begin
      errors++;
      $display("FAIL %s: outputs v=%b d=%h sm=%b st=%b rs=%b ov=%b, expected all 0", name,
               tx_valid, tx_data, ctl_stepmode, ctl_step, ctl_rst, overrun);
    end
  endtask

  task automatic apply_reset();
    @(posedge clk_in);
    #3;
    rst = 1'b1;
    repeat (2) @(posedge clk_in);
    #3;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_in);
    check_outputs_zero("reset_hold");
    @(posedge clk_in);
    #3;
    rst = 1'b0;
    repeat (3) @(negedge clk_in);
    check_outputs_zero("reset_release");
  endtask

  task automatic test_single_step();
    int s0;
    int n = 0;
    send(8'h53);
    get_reply("stepmode_on", 8'h4B, 0);
    s0 = step_cnt;
    send(8'h54);
    while (step_cnt == s0 && n < 3) begin
      @(negedge clk_in);
      n++;
    end
    checks++;
    if (step_cnt == s0) begin
      errors++;
      $display("FAIL step_latency: no ctl_step within %0d cycles of decode", n);
    end
    get_reply("single_step", 8'h4B, 0);
    check_pulses("single_step_pulses", step_cnt - s0, 0, 1, 0);
    send(8'h3F);
    get_reply("status_after_step", 8'h31, 0);
  endtask

  task automatic test_burst();
    int s0 = step_cnt;
    send(8'h4E);
    send(8'h00);
    send(8'h05);
    get_reply("burst5", 8'h4B, 0);
    check_pulses("burst5_pulses", step_cnt - s0, 0, 5, 0);
    s0 = step_cnt;
    send(8'h4E);
    send(8'h00);
    send(8'h00);
    get_reply("burst0", 8'h4B, 0);
    check_pulses("burst0_pulses", step_cnt - s0, 0, 0, 0);
  endtask

  task automatic test_abort();
    int s0 = step_cnt;
    send(8'h4E);
    send(8'h01);
    send(8'h00);
    wait_steps("abort_wait2", s0 + 2);
    send(8'h5A);
    @(negedge clk_in);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set: overrun %b, expected 1", overrun);
    end
    wait_steps("abort_wait4", s0 + 4);
    send(8'h1B);
    get_reply("abort_reply", 8'h41, 0);
    check_pulses("abort_pulses", step_cnt - s0, 0, 4, 0);
    send(8'h3F);
    get_reply("status_overrun", 8'h33, 0);
    send(8'h3F);
    get_reply("status_cleared", 8'h31, 0);
  endtask

  task automatic test_run_mode();
    int s0 = step_cnt;
    send(8'h47);
    get_reply("go", 8'h4B, 0);
    send(8'h54);
    get_reply("step_in_run", 8'h45, 0);
    send(8'h4E);
    get_reply("burst_in_run", 8'h45, 0);
    check_pulses("run_mode_pulses", step_cnt - s0, 0, 0, 0);
    send(8'h3F);
    get_reply("status_run", 8'h30, 0);
  endtask

  task automatic test_timeout();
    int s0;
    int n = 0;
    send(8'h53);
    get_reply("stepmode_on2", 8'h4B, 0);
    busy_mode = 0;
    s0 = step_cnt;
    send(8'h54);
    wait_steps("timeout_pulse", s0 + 1);
    while (!tx_valid && n < 3 * TIMEOUT) begin
      @(negedge clk_in);
      n++;
    end
    checks++;
    if (n < TIMEOUT - 1 || n > TIMEOUT + 1) begin
      errors++;
      $display("FAIL timeout_len: reply after %0d cycles, expected about %0d", n, TIMEOUT);
    end
    get_reply("timeout_hi", 8'h45, 0);
    busy_mode = 2;
    send(8'h54);
    get_reply("timeout_lo", 8'h45, 0);
    busy_mode = 1;
    repeat (3) @(negedge clk_in);
    send(8'h3F);
    get_reply("status_after_timeout", 8'h31, 0);
  endtask

  task automatic test_reset_cmd();
    int s0 = step_cnt;
    int r0 = rst_cnt;
    send(8'h58);
    get_reply("reset_cmd", 8'h4B, 20);
    check_pulses("reset_cmd_pulses", step_cnt - s0, rst_cnt - r0, 0, 1);
  endtask

  task automatic test_reset_mid_burst();
    int s0 = step_cnt;
    send(8'h4E);
    send(8'h00);
    send(8'h10);
    wait_steps("midburst_wait", s0 + 2);
    @(posedge clk_in);
    #3;
    rst = 1'b1;
    #1;
    check_outputs_zero("reset_mid_burst");
    @(posedge clk_in);
    #3;
    rst = 1'b0;
    s0 = step_cnt;
    repeat (30) @(negedge clk_in);
    checks++;
    if (tx_valid !== 1'b0 || ctl_stepmode !== 1'b0) begin
      errors++;
      $display("FAIL after_reset: tx_valid %b stepmode %b, expected 0 0", tx_valid, ctl_stepmode);
    end
    check_pulses("after_reset_pulses", step_cnt - s0, 0, 0, 0);
  endtask

  task automatic test_random();
    bit         m_sm = 1'b0;
    bit         m_ov = 1'b0;
    logic [7:0] b;
    logic [7:0] exp;
    int         s0, r0, es, er, cnt, k, op;
    bit         esc, inj;
    apply_reset();
    for (int it = 0; it < 40; it++) begin
      busy_len = $urandom_range(1, 4);
      op = $urandom_range(0, 6);
      s0 = step_cnt;
      r0 = rst_cnt;
      es = 0;
      er = 0;
      exp = 8'h45;
      case (op)
        0: begin send(8'h53); m_sm = 1'b1; exp = 8'h4B; end
        1: begin send(8'h47); m_sm = 1'b0; exp = 8'h4B; end
        2: begin
          send(8'h54);
          if (m_sm) begin es = 1; exp = 8'h4B; end
        end
        3: begin
          send(8'h4E);
          if (m_sm) begin
            cnt = $urandom_range(0, 6);
            esc = (cnt > 0) && ($urandom_range(0, 1) == 1);
            inj = !esc && (cnt > 1) && ($urandom_range(0, 1) == 1);
            k = esc ? $urandom_range(1, cnt) : cnt;
            send(8'h00);
            send(8'(cnt));
            if (esc) begin
              wait_steps("rand_esc_wait", s0 + k);
              send(8'h1B);
            end
            if (inj) begin
              wait_steps("rand_ovr_wait", s0 + 1);
              send(8'h5A);
              m_ov = 1'b1;
            end
            es  = k;
            exp = (k == cnt) ? 8'h4B : 8'h41;
          end
        end
        4: begin send(8'h58); er = 1; exp = 8'h4B; end
        5: begin send(8'h3F); exp = {6'b001100, m_ov, m_sm}; m_ov = 1'b0; end
        default: begin
          do b = 8'($urandom_range(0, 255));
          while (b inside {8'h53, 8'h47, 8'h54, 8'h4E, 8'h58, 8'h3F});
          send(b);
        end
      endcase
      get_reply($sformatf("rand%0d_op%0d", it, op), exp, $urandom_range(0, 3));
      check_pulses($sformatf("rand%0d_pulses", it), step_cnt - s0, rst_cnt - r0, es, er);
    end
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_burst();
    test_abort();
    test_run_mode();
    test_timeout();
    test_reset_cmd();
    test_reset_mid_burst();
    test_random();
    checks++;
    if (mon_bad != 0) begin
      errors++;
      $display("FAIL pulse_protocol: %0d bad pulse cycles, expected 0", mon_bad);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
